key_loader: RTL



---
 rtl/key_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/key_loader.sv
// Serial key loader: receives a parity-protected key frame LSB-first over a
// valid/ready link and commits it atomically to the parallel key register.
module key_loader #(
   parameter int KEY_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_start,
   input  logic             key_sdata,
   input  logic             key_svalid,
   output logic             key_sready,
   input  logic             key_clear,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             key_done,
   output logic             key_err
);

   // state  | meaning
   // IDLE   | no frame in progress, link not ready
   // SHIFT  | collecting KEY_W data bits, LSB first
   // PARITY | waiting for the odd-parity bit, then commit or reject

   localparam int CNT_W = $clog2(KEY_W + 1);
   localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
   localparam logic [TMO_W-1:0] TMO_MAX  = (TIMEOUT > 0) ? TMO_W'(TIMEOUT) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [KEY_W-1:0]   shift_reg;
   logic [TMO_W-1:0]   tmo_cnt;

   logic accept;
   logic tmo_hit;

   assign accept  = key_svalid & key_sready;
   // The idle cycle that would bring the counter to TIMEOUT ends the frame.
   assign tmo_hit = (TIMEOUT > 0) && !accept && (tmo_cnt >= TMO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         key_sready <= 1'b0;
         key_out    <= '0;
         key_valid  <= 1'b0;
         key_done   <= 1'b0;
         key_err    <= 1'b0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         tmo_cnt    <= '0;
      end else begin
         key_done <= 1'b0;
         key_err  <= 1'b0;
         if (key_clear) begin
            state      <= IDLE;
            key_sready <= 1'b0;
            key_out    <= '0;
            key_valid  <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            tmo_cnt    <= '0;
         end else if (key_start) begin
            state      <= SHIFT;
            key_sready <= 1'b1;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            tmo_cnt    <= '0;
         end else begin
            case (state)
               SHIFT, PARITY: begin
                  if (tmo_hit) begin
                     state      <= IDLE;
                     key_sready <= 1'b0;
                     key_err    <= 1'b1;
                     tmo_cnt    <= TMO_MAX;
                  end else if (accept) begin
                     tmo_cnt <= '0;
                     if (state == SHIFT) begin
                        shift_reg <= {key_sdata, shift_reg[KEY_W-1:1]};
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_LAST)
                           state <= PARITY;
                     end else begin
                        state      <= IDLE;
                        key_sready <= 1'b0;
                        if ((^shift_reg) ^ key_sdata) begin
                           key_out   <= shift_reg;
                           key_valid <= 1'b1;
                           key_done  <= 1'b1;
                        end else begin
                           key_err <= 1'b1;
                        end
                     end
                  end else if ((TIMEOUT > 0) && (tmo_cnt < TMO_MAX)) begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
               end
               default: begin
                  state      <= IDLE;
                  key_sready <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
